// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the fetch-stage PC sequencer.
// State enum plus the select-code constants used by the decoder and the top level.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    localparam logic [1:0] BR_NONE  = 2'b00;
    localparam logic [1:0] BR_EQ    = 2'b01;
    localparam logic [1:0] BR_GT    = 2'b10;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_IMM  = 2'b01;
    localparam logic [1:0] JMP_REG  = 2'b10;

    localparam logic [1:0] NIS_SEQ  = 2'b00;
    localparam logic [1:0] NIS_BR   = 2'b01;
    localparam logic [1:0] NIS_JIMM = 2'b10;
    localparam logic [1:0] NIS_JREG = 2'b11;

endpackage

// File: rtl/pc_redirect_deco.sv
// Combinational redirect decoder: turns EX-stage branch/jump selects and ALU flags
// into a next-instruction select and a redirect strobe.
import pc_seq_pkg::*;

module pc_redirect_deco (
    input  logic [1:0] BranchSel,
    input  logic [1:0] JMPSel,
    input  logic       eq,
    input  logic       bgt,
    input  logic       ex_valid,
    input  logic       in_halt,
    output logic [1:0] NextInstrSel,
    output logic       redirect
);

    // Jumps outrank branches; reserved codes fall through as "no transfer".
    always_comb begin
        NextInstrSel = NIS_SEQ;
        if (ex_valid) begin
            if (JMPSel == JMP_IMM)
                NextInstrSel = NIS_JIMM;
            else if (JMPSel == JMP_REG)
                NextInstrSel = NIS_JREG;
            else if ((BranchSel == BR_EQ) && eq)
                NextInstrSel = NIS_BR;
            else if ((BranchSel == BR_GT) && bgt)
                NextInstrSel = NIS_BR;
        end
    end

    assign redirect = (NextInstrSel != NIS_SEQ) && !in_halt;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: owns the PC register, the RUN/WAIT/HALT
// FSM, instruction-memory request handshake and the redirect flush.
import pc_seq_pkg::*;

module pc_sequencer #(
    parameter int unsigned     PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      BranchSel,
    input  logic [1:0]      JMPSel,
    input  logic            eq,
    input  logic            bgt,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] jump_reg,
    input  logic            stall,
    input  logic            halt,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus,
    output logic [1:0]      NextInstrSel,
    output logic            flush,
    output logic            halted
);

    seq_state_t      r_state;
    seq_state_t      w_nextState;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pcPlus;
    logic [PC_W-1:0] w_target;
    logic [1:0]      w_nis;
    logic            w_redirect;
    logic            w_inHalt;
    logic            w_imemReq;
    logic            w_exValid;

    assign w_inHalt  = (r_state == ST_HALT);
    assign w_exValid = ex_valid && !rst;
    assign w_pcPlus  = r_pc + PC_W'(INSTR_BYTES);

    pc_redirect_deco u_deco (
        .BranchSel    (BranchSel),
        .JMPSel       (JMPSel),
        .eq           (eq),
        .bgt          (bgt),
        .ex_valid     (w_exValid),
        .in_halt      (w_inHalt),
        .NextInstrSel (w_nis),
        .redirect     (w_redirect)
    );

    always_comb begin
        w_target = w_pcPlus;
        case (w_nis)
            NIS_BR:   w_target = branch_target;
            NIS_JIMM: w_target = jump_target;
            NIS_JREG: w_target = jump_reg;
            default:  w_target = w_pcPlus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_RUN;
        else
            r_state <= w_nextState;
    end

    // A redirect abandons any pending fetch, but halt still wins the next state.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_RUN: begin
                if (halt)
                    w_nextState = ST_HALT;
                else if (w_imemReq && !imem_ready && !w_redirect)
                    w_nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (halt)
                    w_nextState = ST_HALT;
                else if (imem_ready || w_redirect)
                    w_nextState = ST_RUN;
            end
            ST_HALT: w_nextState = ST_HALT;
            default: w_nextState = ST_RUN;
        endcase
    end

    always_comb begin
        w_imemReq = !rst && !w_inHalt && !stall;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (w_redirect)
            r_pc <= w_target;
        else if (w_imemReq && imem_ready && !stall)
            r_pc <= w_pcPlus;
    end

    assign imem_req     = w_imemReq;
    assign pc           = r_pc;
    assign pc_plus      = w_pcPlus;
    assign NextInstrSel = w_nis;
    assign flush        = w_redirect;
    assign halted       = w_inHalt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each scenario task queues the expected outputs
// per cycle, a monitor captures what the DUT shows, and the task compares the two.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  BranchSel;
    logic [1:0]  JMPSel;
    logic        eq;
    logic        bgt;
    logic        ex_valid;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jump_reg;
    logic        stall;
    logic        halt;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [1:0]  NextInstrSel;
    logic        flush;
    logic        halted;

    typedef logic [68:0] obs_t;

    obs_t  expQ[$];
    obs_t  obsQ[$];
    string nameQ[$];
    obs_t  obsNow;
    logic  sampleReq = 1'b0;
    int    checks = 0;
    int    passed = 0;

    pc_sequencer #(.PC_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .BranchSel     (BranchSel),
        .JMPSel        (JMPSel),
        .eq            (eq),
        .bgt           (bgt),
        .ex_valid      (ex_valid),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .jump_reg      (jump_reg),
        .stall         (stall),
        .halt          (halt),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .NextInstrSel  (NextInstrSel),
        .flush         (flush),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    assign obsNow = {pc, pc_plus, imem_req, flush, NextInstrSel, halted};

    // Outputs are sampled mid-low-phase, well away from the rising edge.
    always @(negedge clk) begin
        #2;
        if (sampleReq) begin
            obsQ.push_back(obsNow);
            sampleReq = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(negedge clk);
        rst           = 1'b0;
        BranchSel     = BR_NONE;
        JMPSel        = JMP_NONE;
        eq            = 1'b0;
        bgt           = 1'b0;
        ex_valid      = 1'b0;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        jump_reg      = 32'h0;
        stall         = 1'b0;
        halt          = 1'b0;
        imem_ready    = 1'b1;
    endtask

    task automatic expectCycle(input string nm, input logic [31:0] ePc, input logic eReq,
                               input logic eFlush, input logic [1:0] eNis, input logic eHalt);
        expQ.push_back({ePc, ePc + 32'd4, eReq, eFlush, eNis, eHalt});
        nameQ.push_back(nm);
        sampleReq = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        string nm;
        nextCycle(); rst = 1'b1;
        expectCycle("reset_values", 32'h0, 1'b0, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL reset_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_sequential();
        obs_t e, g;
        string nm;
        nextCycle(); expectCycle("seq_pc0", 32'h0, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); expectCycle("seq_pc4", 32'h4, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); expectCycle("seq_pc8", 32'h8, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); expectCycle("seq_pc12", 32'hC, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL seq_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_branch();
        obs_t e, g;
        string nm;
        nextCycle(); BranchSel = BR_EQ; eq = 1'b1; ex_valid = 1'b1; branch_target = 32'h40;
        expectCycle("beq_taken", 32'h10, 1'b1, 1'b1, NIS_BR, 1'b0);
        nextCycle(); JMPSel = JMP_IMM; ex_valid = 1'b1; jump_target = 32'h10;
        expectCycle("beq_target_then_jimm", 32'h40, 1'b1, 1'b1, NIS_JIMM, 1'b0);
        nextCycle(); BranchSel = BR_EQ; eq = 1'b0; ex_valid = 1'b1; branch_target = 32'h40;
        expectCycle("beq_not_taken", 32'h10, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); BranchSel = BR_EQ; eq = 1'b1; ex_valid = 1'b0; branch_target = 32'h40;
        expectCycle("beq_ex_invalid", 32'h14, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL branch_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_jump_priority();
        obs_t e, g;
        string nm;
        nextCycle(); JMPSel = JMP_REG; jump_reg = 32'h100; BranchSel = BR_GT; bgt = 1'b1;
        branch_target = 32'h80; ex_valid = 1'b1;
        expectCycle("jreg_over_branch", 32'h18, 1'b1, 1'b1, NIS_JREG, 1'b0);
        nextCycle(); JMPSel = 2'b11; BranchSel = 2'b11; eq = 1'b1; bgt = 1'b1; ex_valid = 1'b1;
        jump_target = 32'h500; branch_target = 32'h600;
        expectCycle("reserved_codes", 32'h100, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); BranchSel = BR_GT; bgt = 1'b1; ex_valid = 1'b1; branch_target = 32'h20;
        expectCycle("bgt_taken", 32'h104, 1'b1, 1'b1, NIS_BR, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL jump_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_wait();
        obs_t e, g;
        string nm;
        nextCycle(); imem_ready = 1'b0;
        expectCycle("wait_enter", 32'h20, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); imem_ready = 1'b0; JMPSel = JMP_IMM; jump_target = 32'h200; ex_valid = 1'b1;
        expectCycle("wait_jump", 32'h20, 1'b1, 1'b1, NIS_JIMM, 1'b0);
        nextCycle(); imem_ready = 1'b0;
        expectCycle("wait_after_jump", 32'h200, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle();
        expectCycle("wait_accept", 32'h200, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle();
        expectCycle("wait_advanced", 32'h204, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL wait_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_stall();
        obs_t e, g;
        string nm;
        nextCycle(); stall = 1'b1;
        expectCycle("stall_c1", 32'h208, 1'b0, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); stall = 1'b1;
        expectCycle("stall_c2", 32'h208, 1'b0, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); stall = 1'b1; BranchSel = BR_EQ; eq = 1'b1; ex_valid = 1'b1; branch_target = 32'h300;
        expectCycle("stall_redirect", 32'h208, 1'b0, 1'b1, NIS_BR, 1'b0);
        nextCycle();
        expectCycle("stall_target", 32'h300, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL stall_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_halt();
        obs_t e, g;
        string nm;
        nextCycle(); halt = 1'b1; BranchSel = BR_EQ; eq = 1'b1; ex_valid = 1'b1; branch_target = 32'h60;
        expectCycle("halt_with_branch", 32'h304, 1'b1, 1'b1, NIS_BR, 1'b0);
        nextCycle();
        expectCycle("halted_c1", 32'h60, 1'b0, 1'b0, NIS_SEQ, 1'b1);
        nextCycle();
        expectCycle("halted_c2", 32'h60, 1'b0, 1'b0, NIS_SEQ, 1'b1);
        nextCycle(); rst = 1'b1;
        expectCycle("halt_reset_cycle", 32'h60, 1'b0, 1'b0, NIS_SEQ, 1'b1);
        nextCycle();
        expectCycle("halt_after_reset", 32'h0, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL halt_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_reset_in_wait();
        obs_t e, g;
        string nm;
        nextCycle(); imem_ready = 1'b0;
        expectCycle("rw_enter", 32'h4, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); imem_ready = 1'b0;
        expectCycle("rw_waiting", 32'h4, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle(); imem_ready = 1'b0; rst = 1'b1;
        expectCycle("rw_reset_cycle", 32'h4, 1'b0, 1'b0, NIS_SEQ, 1'b0);
        nextCycle();
        expectCycle("rw_after_reset", 32'h0, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle();
        expectCycle("rw_running", 32'h4, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL rw_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    task automatic test_wrap();
        obs_t e, g;
        string nm;
        nextCycle(); JMPSel = JMP_IMM; jump_target = 32'hFFFF_FFFC; ex_valid = 1'b1;
        expectCycle("wrap_jump", 32'h8, 1'b1, 1'b1, NIS_JIMM, 1'b0);
        nextCycle();
        expectCycle("wrap_top", 32'hFFFF_FFFC, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        nextCycle();
        expectCycle("wrap_zero", 32'h0, 1'b1, 1'b0, NIS_SEQ, 1'b0);
        #3;
        if (obsQ.size() != expQ.size()) begin
            checks++;
            $display("[TB] FAIL wrap_samples: got %0d samples, expected %0d", obsQ.size(), expQ.size());
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); g = obsQ.pop_front(); nm = nameQ.pop_front(); checks++;
            if (g !== e)
                $display("[TB] FAIL %s: got pc=%h plus=%h req=%b flush=%b nis=%b halted=%b, expected pc=%h plus=%h req=%b flush=%b nis=%b halted=%b",
                         nm, g[68:37], g[36:5], g[4], g[3], g[2:1], g[0], e[68:37], e[36:5], e[4], e[3], e[2:1], e[0]);
            else passed++;
        end
        expQ.delete(); obsQ.delete(); nameQ.delete();
    endtask

    initial begin
        rst           = 1'b1;
        BranchSel     = BR_NONE;
        JMPSel        = JMP_NONE;
        eq            = 1'b0;
        bgt           = 1'b0;
        ex_valid      = 1'b0;
        branch_target = 32'h0;
        jump_target   = 32'h0;
        jump_reg      = 32'h0;
        stall         = 1'b0;
        halt          = 1'b0;
        imem_ready    = 1'b1;
        repeat (2) @(posedge clk);

        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_wait();
        test_stall();
        test_halt();
        test_reset_in_wait();
        test_wrap();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
